uart_reg_dump: RTL

Parametrised register-dump streamer for the debug UART path. It periodically, or on demand, snapshots all CPU registers and emits one ASCII line per register, `rN=0xHHHH\r\n`, as a byte stream over a valid/ready interface. That interface feeds the UART transmitter wrapper. It supersedes the single-register, fixed-width dumper: register count, width and period are generic, the snapshot is atomic, and backpressure is handled by handshake.

---
 rtl/uart_dump_pkg.sv | 23 ++
 rtl/nibble_to_ascii.sv | 16 +
 rtl/uart_reg_dump.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_dump_pkg.sv
// Shared state encoding, ASCII constants and line geometry for the register-dump streamer.
// Pure declarations: no logic, no latency, no flow control.
package uart_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND
    } state_t;

    localparam logic [7:0] CH_R  = 8'h72;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_X  = 8'h78;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // "rN=0x" + hex digits + CR LF
    function automatic int line_len(input int reg_w);
        return 7 + reg_w / 4;
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Converts a 4-bit value to its uppercase ASCII hex digit.
// Combinational, zero latency; no flow control.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'b0000, nibble};
        end else begin
            ascii = 8'h37 + {4'b0000, nibble};
        end
    end

endmodule

// File: rtl/uart_reg_dump.sv
// Snapshots the register file and streams one "rN=0xHHHH\r\n" line per register.
// First byte two cycles after the start decision; tx_data/tx_valid held stable while tx_ready is low.
module uart_reg_dump
    import uart_dump_pkg::*;
#(
    parameter int NUM_REGS      = 8,
    parameter int REG_W         = 16,
    parameter int PERIOD_CYCLES = 27_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REGS*REG_W-1:0] regs,
    input  logic                      enable,
    input  logic                      trigger,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int             DIGITS    = REG_W / 4;
    localparam int             LINE      = line_len(REG_W);
    localparam logic [3:0]     LAST_CHAR = 4'(LINE - 1);
    localparam logic [3:0]     CR_POS    = 4'(LINE - 2);
    localparam logic [3:0]     LAST_REG  = 4'(NUM_REGS - 1);
    localparam int             CW        = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(PERIOD_CYCLES - 1);

    state_t            state;
    logic [CW-1:0]     period_cnt;
    logic              pending;
    logic [3:0]        reg_idx;
    logic [3:0]        char_idx;
    logic [REG_W-1:0]  regs_arr [16];
    logic [REG_W-1:0]  snap     [16];

    logic              start;
    logic              hs;
    logic              last_char;
    logic              last_byte;
    logic [3:0]        nxt_char;
    logic [3:0]        nxt_reg;
    logic [3:0]        dat_nib;
    logic [7:0]        idx_ascii;
    logic [7:0]        dat_ascii;
    logic [7:0]        nxt_byte;
    int                shamt;

    // Index the snapshot with a full 4-bit pointer; unused slots read as zero.
    for (genvar g = 0; g < 16; g++) begin : g_regs
        if (g < NUM_REGS) begin : g_used
            assign regs_arr[g] = regs[g*REG_W +: REG_W];
        end else begin : g_unused
            assign regs_arr[g] = '0;
        end
    end

    nibble_to_ascii u_idx_hex (
        .nibble (nxt_reg),
        .ascii  (idx_ascii)
    );

    nibble_to_ascii u_dat_hex (
        .nibble (dat_nib),
        .ascii  (dat_ascii)
    );

    // Next character is computed ahead so tx_data can stay registered without bubbles.
    always_comb begin
        start     = (enable && (period_cnt == CNT_LAST || trigger)) || pending;
        hs        = tx_valid && tx_ready;
        last_char = (char_idx == LAST_CHAR);
        last_byte = last_char && (reg_idx == LAST_REG);
        nxt_char  = last_char ? 4'd0 : char_idx + 4'd1;
        nxt_reg   = last_char ? reg_idx + 4'd1 : reg_idx;
        shamt     = 0;
        if (nxt_char >= 4'd5 && nxt_char < CR_POS) begin
            shamt = 4 * (DIGITS - 1 - (int'(nxt_char) - 5));
        end
        dat_nib = 4'(snap[nxt_reg] >> shamt);
        case (nxt_char)
            4'd0:      nxt_byte = CH_R;
            4'd1:      nxt_byte = idx_ascii;
            4'd2:      nxt_byte = CH_EQ;
            4'd3:      nxt_byte = CH_0;
            4'd4:      nxt_byte = CH_X;
            CR_POS:    nxt_byte = CH_CR;
            LAST_CHAR: nxt_byte = CH_LF;
            default:   nxt_byte = dat_ascii;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period_cnt <= '0;
            pending    <= 1'b0;
            reg_idx    <= 4'd0;
            char_idx   <= 4'd0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                snap[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        period_cnt <= '0;
                        pending    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SNAP;
                    end else if (enable) begin
                        period_cnt <= period_cnt + CW'(1);
                    end else begin
                        period_cnt <= '0;
                    end
                end
                SNAP: begin
                    for (int i = 0; i < 16; i++) begin
                        snap[i] <= regs_arr[i];
                    end
                    reg_idx  <= 4'd0;
                    char_idx <= 4'd0;
                    tx_data  <= CH_R;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        if (last_byte) begin
                            tx_valid   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            char_idx <= nxt_char;
                            reg_idx  <= nxt_reg;
                            tx_data  <= nxt_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Requests during a frame collapse into a single follow-on frame.
            if (state != IDLE) begin
                if (!enable) begin
                    pending <= 1'b0;
                end else if (trigger) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule
